// File: rtl/ldst_map_pkg.sv
// Memory map and shared enums for the load/store bus controller and its
// address decoder.
package ldst_map_pkg;

    localparam int MAP_MEM_WORDS = 1024;
    localparam int MAP_PS2_BASE  = 1036;
    localparam int MAP_PS2_LAST  = 1039;

    typedef enum logic [1:0] {
        REG_MEM      = 2'd0,
        REG_PS2      = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_ACC  = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_PS2_REQ  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/addr_region_decode.sv
// Pure combinational word-address to region decoder, shared by the load/store
// controller, the fetch path and the debugger.
module addr_region_decode
    import ldst_map_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = MAP_MEM_WORDS,
    parameter int PS2_BASE  = MAP_PS2_BASE,
    parameter int PS2_LAST  = MAP_PS2_LAST
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_t           region_o
);

    // Unsigned compare; the hole between memory and the PS2 window is unmapped.
    always_comb begin
        region_o = REG_UNMAPPED;
        if (addr_i < ADDR_W'(MEM_WORDS)) begin
            region_o = REG_MEM;
        end else if ((addr_i >= ADDR_W'(PS2_BASE)) && (addr_i <= ADDR_W'(PS2_LAST))) begin
            region_o = REG_PS2;
        end else begin
            region_o = REG_UNMAPPED;
        end
    end

endmodule

// File: rtl/ldst_bus_controller.sv
// Load/store sequencer: routes one core request at a time to data memory or
// the PS/2 register window, stalls the core and returns a one-cycle response.
module ldst_bus_controller
    import ldst_map_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = MAP_MEM_WORDS,
    parameter int PS2_BASE    = MAP_PS2_BASE,
    parameter int PS2_LAST    = MAP_PS2_LAST,
    parameter int MEM_LATENCY = 1,
    parameter int PS2_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         req_ready,
    output logic                         stall,
    output logic                         resp_valid,
    output logic [DATA_W-1:0]            resp_rdata,
    output logic                         resp_err,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         ps2_sel,
    output logic [1:0]                   ps2_reg,
    input  logic                         ps2_ack,
    input  logic [DATA_W-1:0]            ps2_rdata
);

    localparam int         MEM_AW      = $clog2(MEM_WORDS);
    localparam logic [1:0] PS2_BASE_LO = 2'(PS2_BASE);

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         cnt_q, cnt_d;
    region_t             req_region_s;

    addr_region_decode #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS),
        .PS2_BASE  (PS2_BASE),
        .PS2_LAST  (PS2_LAST)
    ) u_decode (
        .addr_i   (req_addr),
        .region_o (req_region_s)
    );

    // State and transaction registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and capture logic; cnt_q times both the memory wait and the PS2 timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[MEM_AW-1:0];
                    write_d = req_write;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = 32'd0;
                    case (req_region_s)
                        REG_MEM: begin
                            err_d   = 1'b0;
                            state_d = ST_MEM_ACC;
                        end
                        REG_PS2: begin
                            // The PS2 window is read-only.
                            err_d   = req_write;
                            state_d = req_write ? ST_RESP : ST_PS2_REQ;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_RESP;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_ACC: begin
                if (write_q) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = 32'd0;
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (cnt_q == 32'(MEM_LATENCY - 1)) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_PS2_REQ: begin
                if (ps2_ack) begin
                    rdata_d = ps2_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == 32'(PS2_TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from state; every output is forced low while rst is high.
    always_comb begin
        req_ready  = 1'b0;
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ps2_sel    = 1'b0;
        ps2_reg    = 2'd0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    req_ready = 1'b1;
                    stall     = req_valid;
                end
                ST_MEM_ACC: begin
                    stall     = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = write_q;
                    mem_addr  = addr_q;
                    mem_wdata = write_q ? wdata_q : '0;
                end
                ST_MEM_WAIT: begin
                    stall    = 1'b1;
                    mem_addr = addr_q;
                end
                ST_PS2_REQ: begin
                    stall   = 1'b1;
                    ps2_sel = 1'b1;
                    ps2_reg = addr_q[1:0] - PS2_BASE_LO;
                end
                ST_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_err   = err_q;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end else begin
            stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_ldst_bus_controller.sv
// Directed plus randomized bench for ldst_bus_controller; expected responses
// come from a transaction-level model of the memory map and timing rules.
module tb_ldst_bus_controller;

    localparam int MEM_LATENCY = 1;
    localparam int PS2_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        ps2_sel, ps2_ack;
    logic [1:0]  ps2_reg;
    logic [31:0] ps2_rdata;

    logic [31:0] tb_mem  [1024];
    logic [31:0] ref_mem [1024];
    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ldst_bus_controller #(
        .MEM_LATENCY (MEM_LATENCY),
        .PS2_TIMEOUT (PS2_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .ps2_sel    (ps2_sel),
        .ps2_reg    (ps2_reg),
        .ps2_ack    (ps2_ack),
        .ps2_rdata  (ps2_rdata)
    );

    // Single-cycle-latency synchronous RAM standing in for data memory.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " resp_valid"}, resp_valid, 0);
        chk({tag, " resp_rdata"}, resp_rdata, 0);
        chk({tag, " resp_err"},   resp_err, 0);
        chk({tag, " stall"},      stall, 0);
        chk({tag, " mem_en"},     mem_en, 0);
        chk({tag, " mem_we"},     mem_we, 0);
        chk({tag, " mem_addr"},   mem_addr, 0);
        chk({tag, " mem_wdata"},  mem_wdata, 0);
        chk({tag, " ps2_sel"},    ps2_sel, 0);
        chk({tag, " ps2_reg"},    ps2_reg, 0);
        chk({tag, " req_ready"},  req_ready, 0);
    endtask

    // One complete transaction; ack_d is the 0-based PS2_REQ cycle in which ack is driven.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input int ack_d);
        int          region, rc;
        logic [31:0] rd, pv;
        logic        err, ps2_load;
        string       t;
        pv  = $urandom;
        rd  = 32'd0;
        err = 1'b0;
        if (addr < 32'd1024) region = 0;
        else if (addr >= 32'd1036 && addr <= 32'd1039) region = 1;
        else region = 2;
        ps2_load = (region == 1) && !wr;
        if (region == 0 && wr) rc = 2;
        else if (region == 0) begin
            rc = 2 + MEM_LATENCY;
            rd = ref_mem[addr[9:0]];
        end else if (ps2_load && ack_d < PS2_TIMEOUT) begin
            rc = 2 + ack_d;
            rd = pv;
        end else if (ps2_load) begin
            rc  = 1 + PS2_TIMEOUT;
            err = 1'b1;
        end else begin
            rc  = 1;
            err = 1'b1;
        end

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; ps2_ack = 1'b0;
        #1;
        t = $sformatf("a%0h w%0d", addr, wr);
        chk({t, " c0 req_ready"}, req_ready, 1);
        chk({t, " c0 stall"}, stall, 1);
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            ps2_ack   = (ps2_load && (c - 1) == ack_d) ? 1'b1 : 1'b0;
            ps2_rdata = ps2_ack ? pv : $urandom;
            #1;
            t = $sformatf("a%0h w%0d c%0d", addr, wr, c);
            chk({t, " resp_valid"}, resp_valid, (c == rc));
            chk({t, " resp_rdata"}, resp_rdata, (c == rc) ? rd : 32'd0);
            chk({t, " resp_err"},   resp_err, (c == rc) ? err : 1'b0);
            chk({t, " stall"},      stall, (c < rc));
            chk({t, " req_ready"},  req_ready, 0);
            chk({t, " mem_en"},     mem_en, (region == 0 && c == 1));
            chk({t, " mem_we"},     mem_we, (region == 0 && wr && c == 1));
            chk({t, " ps2_sel"},    ps2_sel, (ps2_load && c < rc));
            if (region == 0 && c == 1) chk({t, " mem_addr"}, mem_addr, addr[9:0]);
            if (region == 0 && wr && c == 1) chk({t, " mem_wdata"}, mem_wdata, wd);
            if (ps2_load && c < rc) chk({t, " ps2_reg"}, ps2_reg, 2'(addr - 32'd1036));
        end
        ps2_ack = 1'b0;
        if (region == 0 && wr) ref_mem[addr[9:0]] = wd;
        @(negedge clk);
        #1;
        chk({t, " after req_ready"}, req_ready, 1);
        chk({t, " after resp_valid"}, resp_valid, 0);
    endtask

    // Start a load, then hit rst during cycle abort_c of the transaction.
    task automatic abort_txn(input logic [31:0] addr, input int abort_c);
        string t;
        t = $sformatf("abort a%0h", addr);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; ps2_ack = 1'b0;
        for (int c = 1; c <= abort_c; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        #1;
        chk({t, " busy stall"}, stall, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero(t);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk({t, " idle req_ready"}, req_ready, 1);
        chk({t, " idle resp_valid"}, resp_valid, 0);
        chk({t, " idle stall"}, stall, 0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 32'hA5A5_0000 ^ 32'(i);
            ref_mem[i] = 32'hA5A5_0000 ^ 32'(i);
        end
        tb_mem[5]  = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        ps2_ack = 1'b0; ps2_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset req_ready", req_ready, 1);
        chk("reset stall", stall, 0);

        run_txn(32'd5, 1'b0, 32'd0, 0);
        run_txn(32'd1023, 1'b1, 32'h1234_5678, 0);
        run_txn(32'd1023, 1'b0, 32'd0, 0);
        run_txn(32'd1037, 1'b0, 32'd0, 2);
        run_txn(32'd1024, 1'b0, 32'd0, 0);
        run_txn(32'd1035, 1'b1, 32'h5555_AAAA, 0);
        run_txn(32'd1040, 1'b0, 32'd0, 0);
        run_txn(32'hFFFF_FFFF, 1'b0, 32'd0, 0);
        run_txn(32'd1036, 1'b1, 32'hCAFE_F00D, 0);
        run_txn(32'd1039, 1'b0, 32'd0, 99);
        run_txn(32'd1038, 1'b0, 32'd0, PS2_TIMEOUT - 1);
        run_txn(32'd1036, 1'b0, 32'd0, 0);

        abort_txn(32'd1036, 4);
        abort_txn(32'd77, 2);
        run_txn(32'd77, 1'b0, 32'd0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: a = $urandom_range(0, 1023);
                1: a = $urandom_range(1036, 1039);
                2: a = $urandom_range(1024, 1035);
                3: a = $urandom_range(1040, 1100);
                4: a = $urandom;
                default: a = $urandom_range(1020, 1043);
            endcase
            run_txn(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 18)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
